// File: rtl/sync_updown_counter.sv
// sync_updown_counter: prescaled up/down counter with programmable modulus, wrap/saturate,
// parallel load, terminal-count pulse and sticky overflow flag.
module sync_updown_counter #(
  parameter int WID_COUNT = 6,
  parameter int WID_PRESCALE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    sat_mode,
  input  logic [WID_COUNT-1:0]    modulus,
  input  logic [WID_PRESCALE-1:0] prescale,
  input  logic                    load,
  input  logic [WID_COUNT-1:0]    load_val,
  input  logic                    clr_ovf,
  output logic [WID_COUNT-1:0]    result,
  output logic                    tc,
  output logic                    ovf
);
  logic [WID_PRESCALE-1:0] pre_cnt;
  logic                    tick;
  logic                    bnd;
  logic [WID_COUNT-1:0]    nxt;
  logic [WID_COUNT-1:0]    ld;
  always_comb begin
    tick = en && (pre_cnt >= prescale);
    ld   = (load_val > modulus) ? modulus : load_val;
    // boundaries are detected before stepping, so no step ever carries out
    bnd  = tick && (up ? (result >= modulus) : (result == '0));
    nxt  = up ? ((result >= modulus) ? (sat_mode ? modulus : '0) : result + 1'b1)
              : (result > modulus) ? modulus
              : (result == '0) ? (sat_mode ? '0 : modulus)
              : result - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result  <= '0;
      pre_cnt <= '0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      result  <= ld;
      pre_cnt <= '0;
      tc      <= 1'b0;
      ovf     <= ovf & ~clr_ovf;
    end else begin
      if (en) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) result <= nxt;
      tc  <= bnd;
      ovf <= bnd | (ovf & ~clr_ovf);
    end
  end
endmodule

// File: tb/tb_sync_updown_counter.sv
// tb_sync_updown_counter: directed stimulus pushes hand-computed expectations into a queue;
// an independent monitor pops and compares one entry per clock edge.
module tb_sync_updown_counter;
  logic       clk = 1'b0;
  logic       rst_n, en, up, sat_mode, load, clr_ovf;
  logic [5:0] modulus, load_val, result;
  logic [3:0] prescale;
  logic       tc, ovf;
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    logic [5:0] r;
    logic       t;
    logic       o;
    string      nm;
  } exp_t;
  exp_t q[$];

  sync_updown_counter #(.WID_COUNT(6), .WID_PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat_mode(sat_mode),
    .modulus(modulus), .prescale(prescale), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .result(result), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 3;
      if (result !== e.r) begin
        failures++;
        $display("FAIL %s result got=%0d exp=%0d t=%0t", e.nm, result, e.r, $time);
      end
      if (tc !== e.t) begin
        failures++;
        $display("FAIL %s tc got=%b exp=%b t=%0t", e.nm, tc, e.t, $time);
      end
      if (ovf !== e.o) begin
        failures++;
        $display("FAIL %s ovf got=%b exp=%b t=%0t", e.nm, ovf, e.o, $time);
      end
    end
  end

  task automatic go(input logic [5:0] r, input logic t, input logic o, input string nm);
    exp_t e;
    e.r = r; e.t = t; e.o = o; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; en = 0; up = 1; sat_mode = 0; load = 0; clr_ovf = 0;
    modulus = 9; prescale = 0; load_val = 0;
    @(negedge clk);
    go(0, 0, 0, "reset0");
    go(0, 0, 0, "reset1");
    // up wrap at modulus 9
    rst_n = 1; en = 1;
    for (int i = 1; i <= 9; i++) go(6'(i), 0, 0, "up_count");
    go(0, 1, 1, "up_wrap");
    go(1, 0, 1, "after_wrap1");
    go(2, 0, 1, "after_wrap2");
    clr_ovf = 1;
    go(3, 0, 0, "clr_ovf");
    clr_ovf = 0;
    go(4, 0, 0, "count4");
    go(5, 0, 0, "count5");
    // reset mid-count overrides load and enable
    rst_n = 0; load = 1; load_val = 7;
    go(0, 0, 0, "reset_mid");
    rst_n = 1; load = 0;
    go(1, 0, 0, "resume1");
    go(2, 0, 0, "resume2");
    // prescale 3: one step every 4 enabled cycles
    prescale = 3;
    for (int i = 0; i < 3; i++) go(2, 0, 0, "pre_wait_a");
    go(3, 0, 0, "pre_step_a");
    for (int i = 0; i < 3; i++) go(3, 0, 0, "pre_wait_b");
    go(4, 0, 0, "pre_step_b");
    go(4, 0, 0, "pre_gap_en");
    en = 0;
    go(4, 0, 0, "pre_gap_off1");
    go(4, 0, 0, "pre_gap_off2");
    en = 1;
    go(4, 0, 0, "pre_gap_on1");
    go(4, 0, 0, "pre_gap_on2");
    go(5, 0, 0, "pre_gap_step");
    // load on a tick cycle with clamp
    modulus = 40; load_val = 50;
    for (int i = 0; i < 3; i++) go(5, 0, 0, "pre_to_tick");
    load = 1;
    go(40, 0, 0, "load_clamp");
    load = 0;
    for (int i = 0; i < 3; i++) go(40, 0, 0, "load_restart");
    clr_ovf = 1;
    go(0, 1, 1, "wrap_clr_collide");
    clr_ovf = 0;
    for (int i = 0; i < 3; i++) go(0, 0, 1, "ovf_sticky");
    go(1, 0, 1, "step_after_wrap");
    clr_ovf = 1;
    go(1, 0, 0, "clr_ovf2");
    clr_ovf = 0;
    // down saturate from 2
    prescale = 0; load_val = 2; load = 1;
    go(2, 0, 0, "load2");
    load = 0; up = 0; sat_mode = 1;
    go(1, 0, 0, "down1");
    go(0, 0, 0, "down0");
    go(0, 1, 1, "down_sat1");
    go(0, 1, 1, "down_sat2");
    sat_mode = 0;
    go(40, 1, 1, "down_wrap");
    go(39, 0, 1, "down39");
    modulus = 10;
    go(10, 0, 1, "mod_lowered");
    up = 1; sat_mode = 1;
    go(10, 1, 1, "up_sat1");
    go(10, 1, 1, "up_sat2");
    // modulus 0: every tick is a boundary
    modulus = 0; sat_mode = 0;
    go(0, 1, 1, "mod0_a");
    go(0, 1, 1, "mod0_b");
    go(0, 1, 1, "mod0_c");
    clr_ovf = 1;
    go(0, 1, 1, "mod0_collide");
    en = 0;
    go(0, 0, 0, "mod0_idle_clr");
    clr_ovf = 0;
    // lowering prescale below pre_cnt ticks on next enabled edge
    modulus = 9; prescale = 5; en = 1;
    for (int i = 0; i < 3; i++) go(0, 0, 0, "pre_hi_wait");
    prescale = 1;
    go(1, 0, 0, "pre_lowered");
    go(1, 0, 0, "pre1_wait");
    go(2, 0, 0, "pre1_step");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
